// File: rtl/alu_n8_pkg.sv
// Shared constants and types for the sequential 32-bit adder built from one 8-bit slice.
// The optional ALU_ADD_SEQ_OVERFLOW_EN build adds signed-overflow reporting.
package alu_n8_pkg;

    localparam int WIDTH_DFLT  = 32;
    localparam int SLICE_DFLT  = 8;
    localparam int NBEATS_DFLT = WIDTH_DFLT / SLICE_DFLT;

    // A one-beat configuration still needs a 1-bit counter.
    function automatic int beat_w(input int nbeats);
        return (nbeats > 1) ? $clog2(nbeats) : 1;
    endfunction

    localparam int BEAT_W = beat_w(NBEATS_DFLT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_n8_add_slice.sv
// Combinational SLICE-bit adder: s/co = a + b + ci.
// With ALU_ADD_SEQ_OVERFLOW_EN it also exposes the carry into its MSB.
module alu_n8_add_slice
    import alu_n8_pkg::*;
#(
    parameter int SLICE = SLICE_DFLT
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             ci_i,
    output logic [SLICE-1:0] s_o,
    output logic             co_o
`ifdef ALU_ADD_SEQ_OVERFLOW_EN
    ,
    output logic             msb_ci_o
`endif
);

`ifdef ALU_ADD_SEQ_OVERFLOW_EN
    // Split at the MSB so the carry into it is visible for the overflow term.
    logic [SLICE-1:0] low;
    logic [1:0]       top;

    assign low = {1'b0, a_i[SLICE-2:0]} + {1'b0, b_i[SLICE-2:0]} + {{(SLICE-1){1'b0}}, ci_i};
    assign msb_ci_o = low[SLICE-1];
    assign top = {1'b0, a_i[SLICE-1]} + {1'b0, b_i[SLICE-1]} + {1'b0, low[SLICE-1]};
    assign s_o  = {top[0], low[SLICE-2:0]};
    assign co_o = top[1];
`else
    logic [SLICE:0] full;

    assign full = {1'b0, a_i} + {1'b0, b_i} + {{SLICE{1'b0}}, ci_i};
    assign s_o  = full[SLICE-1:0];
    assign co_o = full[SLICE];
`endif

endmodule

// File: rtl/alu_n8_add_seq.sv
// Multi-cycle WIDTH-bit adder reusing one SLICE-bit adder, one slice per beat.
// Define ALU_ADD_SEQ_OVERFLOW_EN to add the signed-overflow output ovf.
module alu_n8_add_seq
    import alu_n8_pkg::*;
#(
    parameter int WIDTH = WIDTH_DFLT,
    parameter int SLICE = SLICE_DFLT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             zero,
    output state_e           state_dbg
`ifdef ALU_ADD_SEQ_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int NBEATS = WIDTH / SLICE;
    localparam int BW     = beat_w(NBEATS);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // the producer keeps its data stable while valid is high and ready is low.

    state_e           state_q;
    logic [BW-1:0]    beat_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d, sum_q;
    logic             co_q, zero_q, out_valid_q;
    logic [SLICE-1:0] sl_s;
    logic             sl_co;
    logic             last_beat;
    int               lsb;

`ifdef ALU_ADD_SEQ_OVERFLOW_EN
    logic             sl_msb_ci;
    logic             ovf_q;
`endif

    assign lsb       = int'(beat_q) * SLICE;
    assign last_beat = (beat_q == BW'(NBEATS - 1));

    alu_n8_add_slice #(.SLICE(SLICE)) u_slice (
        .a_i      (a_q[lsb +: SLICE]),
        .b_i      (b_q[lsb +: SLICE]),
        .ci_i     (carry_q),
        .s_o      (sl_s),
        .co_o     (sl_co)
`ifdef ALU_ADD_SEQ_OVERFLOW_EN
        ,
        .msb_ci_o (sl_msb_ci)
`endif
    );

    // Partial sums live in acc_q so the visible sum only changes on the final beat.
    always_comb begin
        acc_d              = acc_q;
        acc_d[lsb +: SLICE] = sl_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            co_q        <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef ALU_ADD_SEQ_OVERFLOW_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= ci;
                        beat_q  <= '0;
                        acc_q   <= '0;
                        sum_q   <= '0;
                        co_q    <= 1'b0;
                        zero_q  <= 1'b0;
`ifdef ALU_ADD_SEQ_OVERFLOW_EN
                        ovf_q   <= 1'b0;
`endif
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= sl_co;
                    beat_q  <= beat_q + 1'b1;
                    if (last_beat) begin
                        beat_q      <= '0;
                        sum_q       <= acc_d;
                        co_q        <= sl_co;
                        zero_q      <= (acc_d == '0);
`ifdef ALU_ADD_SEQ_OVERFLOW_EN
                        ovf_q       <= sl_msb_ci ^ sl_co;
`endif
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign co        = co_q;
    assign zero      = zero_q;
    assign state_dbg = state_q;
`ifdef ALU_ADD_SEQ_OVERFLOW_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_alu_n8_add_seq.sv
// Self-checking bench for alu_n8_add_seq: directed and random additions, backpressure, resets.
module tb_alu_n8_add_seq;
    import alu_n8_pkg::*;

    localparam int W  = 32;
    localparam int EW = W + 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ci = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         co;
    logic         zero;
    state_e       state_dbg;
`ifdef ALU_ADD_SEQ_OVERFLOW_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [EW-1:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    alu_n8_add_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co),
        .zero      (zero),
        .state_dbg (state_dbg)
`ifdef ALU_ADD_SEQ_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference: {ovf, zero, co, sum}
    function automatic logic [EW-1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                            input logic civ);
        logic [W:0]   full;
        logic [W-1:0] s;
        logic         v;
        full = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, civ};
        s    = full[W-1:0];
        v    = (av[W-1] == bv[W-1]) && (s[W-1] != av[W-1]);
        return {v, (s == '0), full[W], s};
    endfunction

    // driver: called and returns on a negedge; returns at the negedge after acceptance
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic civ);
        int k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("in_ready_wait", in_ready, 1);
        in_valid = 1'b1;
        a  = av;
        b  = bv;
        ci = civ;
        exp_q.push_back(model(av, bv, civ));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a  = $urandom;
        b  = $urandom;
        ci = 1'($urandom_range(0, 1));
        check("in_ready_run", in_ready, 0);
    endtask

    // scoreboard pop: wait for result, compare, optionally stall, then complete handshake
    task automatic collect(input int hold);
        int k = 0;
        logic [EW-1:0] e;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("latency", k, 4);
        if (exp_q.size() == 0) begin
            check("exp_q_nonempty", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        if (!out_valid) return;
        check("sum", sum, e[W-1:0]);
        check("co", co, e[W]);
        check("zero", zero, e[W+1]);
`ifdef ALU_ADD_SEQ_OVERFLOW_EN
        check("ovf", ovf, e[W+2]);
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = $urandom;
            b = $urandom;
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_sum", sum, e[W-1:0]);
            check("hold_co", co, e[W]);
            check("hold_zero", zero, e[W+1]);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_drop", out_valid, 0);
        check("in_ready_idle", in_ready, 1);
    endtask

    logic [W-1:0] dir_a [7] = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF,
                                32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000};
    logic [W-1:0] dir_b [7] = '{32'h0000_0001, 32'h0000_0001, 32'h1111_1111, 32'hFFFF_FFFF,
                                32'h0000_0001, 32'h8000_0000, 32'h0000_0000};
    logic         dir_c [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        int seen;
        int k;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_co", co, 0);
        check("rst_zero", zero, 0);
        check("rst_state", state_dbg, IDLE);
        rst = 1'b0;
        #1;
        check("rel_in_ready", in_ready, 1);
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            send(dir_a[i], dir_b[i], dir_c[i]);
            collect((i == 1) ? 10 : 0);
        end

        for (int i = 0; i < 8; i++) begin
            send($urandom, $urandom, 1'($urandom_range(0, 1)));
            collect($urandom_range(0, 3));
        end

        // reset during RUN beat 2
        send(32'hDEAD_BEEF, 32'h0102_0304, 1'b0);
        repeat (2) @(negedge clk);
        check("mid_run_state", state_dbg, RUN);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_run_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        check("abort_run_in_ready", in_ready, 1);
        check("abort_run_valid", out_valid, 0);
        check("abort_run_sum", sum, 0);
        check("abort_run_co", co, 0);
        check("abort_run_zero", zero, 0);
        void'(exp_q.pop_back());
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_run_no_valid", seen, 0);
        send(32'h0000_0001, 32'h0000_0001, 1'b0);
        collect(0);

        // reset while holding a result in DONE
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("done_reached", out_valid, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_done_valid", out_valid, 0);
        check("abort_done_co", co, 0);
        check("abort_done_zero", zero, 0);
        check("abort_done_in_ready", in_ready, 1);
        void'(exp_q.pop_back());
        @(negedge clk);
        send(32'h0000_0001, 32'h0000_0001, 1'b0);
        collect(0);

        check("exp_q_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
